// File: rtl/fragment_mem_pkg.sv
// rtl/fragment_mem_pkg.sv - shared types and op codes for the fragment memory arbiter
package fragment_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    SRC_IC = 1'b0,
    SRC_DC = 1'b1
  } src_t;

  // op[2] selects store, op[1:0] is the access size
  localparam logic [2:0] OP_LB = 3'b000;
  localparam logic [2:0] OP_LH = 3'b001;
  localparam logic [2:0] OP_LW = 3'b010;
  localparam logic [2:0] OP_SB = 3'b100;
  localparam logic [2:0] OP_SH = 3'b101;
  localparam logic [2:0] OP_SW = 3'b110;

endpackage

// File: rtl/fragment_mem_arbiter_rr.sv
// rtl/fragment_mem_arbiter_rr.sv - two-way round-robin pick between icache and data side
module rr_arbiter2
  import fragment_mem_pkg::*;
(
  input  logic req_ic,
  input  logic req_dc,
  input  src_t last_owner,
  output logic gnt_ic,
  output logic gnt_dc
);

  // On a tie the side that did not own the previous transaction wins
  always_comb begin
    gnt_ic = req_ic && (!req_dc || (last_owner == SRC_DC));
    gnt_dc = req_dc && (!req_ic || (last_owner == SRC_IC));
  end

endmodule

// File: rtl/fragment_mem_arbiter.sv
// rtl/fragment_mem_arbiter.sv - single-outstanding arbiter for the shared fragment memory port
// Optional grant/stall counters are built when FRAG_MEM_ARB_PERF_EN is defined.
module fragment_mem_arbiter
  import fragment_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ic_req_valid,
  output logic                  ic_req_ready,
  input  logic [ADDR_WIDTH-1:0] ic_req_addr,
  input  logic                  ic_kill,
  output logic                  ic_rsp_valid,
  output logic [DATA_WIDTH-1:0] ic_rsp_data,
  input  logic                  dc_req_valid,
  output logic                  dc_req_ready,
  input  logic [ADDR_WIDTH-1:0] dc_req_addr,
  input  logic [DATA_WIDTH-1:0] dc_req_data,
  input  logic [OP_WIDTH-1:0]   dc_req_op,
  output logic                  dc_rsp_valid,
  output logic [DATA_WIDTH-1:0] dc_rsp_data,
  output logic                  mem_a_valid,
  input  logic                  mem_a_ready,
  output logic [ADDR_WIDTH-1:0] mem_a_addr,
  output logic [DATA_WIDTH-1:0] mem_a_data,
  output logic [OP_WIDTH-1:0]   mem_a_op,
  output logic                  mem_a_src,
  input  logic                  mem_d_valid,
  input  logic [DATA_WIDTH-1:0] mem_d_data
`ifdef FRAG_MEM_ARB_PERF_EN
  ,
  output logic [31:0]           perf_ic_grants,
  output logic [31:0]           perf_dc_grants,
  output logic [31:0]           perf_stall_cycles
`endif
);

  arb_state_t state;
  arb_state_t state_nxt;
  src_t       last_owner;
  src_t       own_src;
  logic [ADDR_WIDTH-1:0] own_addr;
  logic [DATA_WIDTH-1:0] own_data;
  logic [OP_WIDTH-1:0]   own_op;
  logic kill_q;
  logic kill_now;
  logic gnt_ic;
  logic gnt_dc;
  logic grant;
  logic rsp_fire;

  rr_arbiter2 u_rr (
    .req_ic     (ic_req_valid),
    .req_dc     (dc_req_valid),
    .last_owner (last_owner),
    .gnt_ic     (gnt_ic),
    .gnt_dc     (gnt_dc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant)       state_nxt = ISSUE;
      ISSUE:   if (mem_a_ready) state_nxt = WAIT;
      WAIT:    if (mem_d_valid) state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // Accept pulses are combinational so the requester sees them in the grant cycle
  always_comb begin
    ic_req_ready = 1'b0;
    dc_req_ready = 1'b0;
    mem_a_valid  = 1'b0;
    case (state)
      IDLE: begin
        ic_req_ready = gnt_ic && !rst;
        dc_req_ready = gnt_dc && !rst;
      end
      ISSUE:   mem_a_valid = 1'b1;
      default: ;
    endcase
  end

  assign grant      = ic_req_ready || dc_req_ready;
  assign rsp_fire   = (state == WAIT) && mem_d_valid;
  assign mem_a_addr = own_addr;
  assign mem_a_data = own_data;
  assign mem_a_op   = own_op;
  assign mem_a_src  = own_src;

  always_ff @(posedge clk) begin
    if (rst) begin
      own_addr <= '0;
      own_data <= '0;
      own_op   <= '0;
      own_src  <= SRC_IC;
    end else if (ic_req_ready) begin
      own_addr <= ic_req_addr;
      own_data <= '0;
      own_op   <= OP_WIDTH'(OP_LW);
      own_src  <= SRC_IC;
    end else if (dc_req_ready) begin
      own_addr <= dc_req_addr;
      own_data <= dc_req_data;
      own_op   <= dc_req_op;
      own_src  <= SRC_DC;
    end
  end

  // A flush arriving in the same cycle as the response must still suppress it
  assign kill_now = kill_q || (ic_kill && (own_src == SRC_IC));

  always_ff @(posedge clk) begin
    if (rst || (state == IDLE) || rsp_fire) begin
      kill_q <= 1'b0;
    end else if (ic_kill && (own_src == SRC_IC)) begin
      kill_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_owner   <= SRC_DC;
      ic_rsp_valid <= 1'b0;
      ic_rsp_data  <= '0;
      dc_rsp_valid <= 1'b0;
      dc_rsp_data  <= '0;
    end else begin
      ic_rsp_valid <= 1'b0;
      dc_rsp_valid <= 1'b0;
      if (rsp_fire) begin
        last_owner <= own_src;
        if (own_src == SRC_IC) begin
          if (!kill_now) begin
            ic_rsp_valid <= 1'b1;
            ic_rsp_data  <= mem_d_data;
          end
        end else begin
          dc_rsp_valid <= 1'b1;
          dc_rsp_data  <= own_op[2] ? '0 : mem_d_data;
        end
      end
    end
  end

`ifdef FRAG_MEM_ARB_PERF_EN
  logic stall_cycle;

  assign stall_cycle = (ic_req_valid && !ic_req_ready) || (dc_req_valid && !dc_req_ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ic_grants    <= '0;
      perf_dc_grants    <= '0;
      perf_stall_cycles <= '0;
    end else begin
      if (ic_req_ready) perf_ic_grants    <= perf_ic_grants + 32'd1;
      if (dc_req_ready) perf_dc_grants    <= perf_dc_grants + 32'd1;
      if (stall_cycle)  perf_stall_cycles <= perf_stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fragment_mem_arbiter.sv
// tb/tb_fragment_mem_arbiter.sv - scoreboard bench for fragment_mem_arbiter
// Checks the perf counters too when FRAG_MEM_ARB_PERF_EN is defined.
module tb_fragment_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_req_valid, ic_req_ready, ic_kill, ic_rsp_valid;
  logic [31:0] ic_req_addr, ic_rsp_data;
  logic        dc_req_valid, dc_req_ready, dc_rsp_valid;
  logic [31:0] dc_req_addr, dc_req_data, dc_rsp_data;
  logic [2:0]  dc_req_op;
  logic        mem_a_valid, mem_a_ready, mem_a_src, mem_d_valid;
  logic [31:0] mem_a_addr, mem_a_data, mem_d_data;
  logic [2:0]  mem_a_op;
`ifdef FRAG_MEM_ARB_PERF_EN
  logic [31:0] perf_ic_grants, perf_dc_grants, perf_stall_cycles;
  int unsigned p_ic, p_dc, p_st;
`endif

  always #5 clk = ~clk;

  fragment_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ic_req_valid(ic_req_valid), .ic_req_ready(ic_req_ready), .ic_req_addr(ic_req_addr),
    .ic_kill(ic_kill), .ic_rsp_valid(ic_rsp_valid), .ic_rsp_data(ic_rsp_data),
    .dc_req_valid(dc_req_valid), .dc_req_ready(dc_req_ready), .dc_req_addr(dc_req_addr),
    .dc_req_data(dc_req_data), .dc_req_op(dc_req_op),
    .dc_rsp_valid(dc_rsp_valid), .dc_rsp_data(dc_rsp_data),
    .mem_a_valid(mem_a_valid), .mem_a_ready(mem_a_ready), .mem_a_addr(mem_a_addr),
    .mem_a_data(mem_a_data), .mem_a_op(mem_a_op), .mem_a_src(mem_a_src),
    .mem_d_valid(mem_d_valid), .mem_d_data(mem_d_data)
`ifdef FRAG_MEM_ARB_PERF_EN
    ,
    .perf_ic_grants(perf_ic_grants), .perf_dc_grants(perf_dc_grants),
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  typedef struct {
    logic        src;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  op;
  } req_t;

  typedef struct {
    logic        src;
    logic [31:0] data;
  } rsp_t;

  req_t ic_q[$];
  req_t dc_q[$];
  rsp_t exp_rsp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding transaction, tie goes to the side that did not own the last one
  bit          busy = 1'b0, sent = 1'b0, killed = 1'b0, m_last = 1'b1, after_rst = 1'b0;
  int          busy_cycles = 0;
  req_t        cur;
  logic [31:0] m_ic_data = '0, m_dc_data = '0;

  always @(negedge clk) begin
    rsp_t r;
    bit   e_ic, e_dc, x_ic, x_dc;
    if (rst) begin
      chk("ready_during_reset", {ic_req_ready, dc_req_ready}, 64'd0);
      busy = 0; sent = 0; killed = 0; m_last = 1; after_rst = 1;
      m_ic_data = '0; m_dc_data = '0;
      exp_rsp_q.delete();
`ifdef FRAG_MEM_ARB_PERF_EN
      p_ic = 0; p_dc = 0; p_st = 0;
`endif
    end else begin
      if (after_rst) begin
        chk("post_reset_bus_fields", {mem_a_addr, mem_a_data, mem_a_op, mem_a_src}, 64'd0);
        after_rst = 0;
      end
      x_ic = 0; x_dc = 0;
      if (exp_rsp_q.size() > 0) begin
        r = exp_rsp_q.pop_front();
        if (r.src) begin x_dc = 1; m_dc_data = r.data; end
        else       begin x_ic = 1; m_ic_data = r.data; end
      end
      chk("ic_rsp_valid", ic_rsp_valid, x_ic);
      chk("dc_rsp_valid", dc_rsp_valid, x_dc);
      chk("ic_rsp_data", ic_rsp_data, m_ic_data);
      chk("dc_rsp_data", dc_rsp_data, m_dc_data);

      e_ic = !busy && ic_req_valid && (!dc_req_valid || m_last);
      e_dc = !busy && dc_req_valid && (!ic_req_valid || !m_last);
      chk("ic_req_ready", ic_req_ready, e_ic);
      chk("dc_req_ready", dc_req_ready, e_dc);
`ifdef FRAG_MEM_ARB_PERF_EN
      chk("perf_ic_grants", perf_ic_grants, p_ic);
      chk("perf_dc_grants", perf_dc_grants, p_dc);
      chk("perf_stall_cycles", perf_stall_cycles, p_st);
      p_ic += e_ic;
      p_dc += e_dc;
      if ((ic_req_valid && !e_ic) || (dc_req_valid && !e_dc)) p_st++;
`endif

      if (!busy) begin
        chk("mem_a_valid_idle", mem_a_valid, 1'b0);
      end else if (!sent) begin
        chk("mem_a_valid", mem_a_valid, 1'b1);
        chk("mem_a_addr", mem_a_addr, cur.addr);
        chk("mem_a_op", mem_a_op, cur.op);
        chk("mem_a_src", mem_a_src, cur.src);
        if (cur.src) chk("mem_a_data", mem_a_data, cur.data);
        if (!cur.src && ic_kill) killed = 1;
        if (mem_a_ready) sent = 1;
      end else begin
        chk("mem_a_valid_wait", mem_a_valid, 1'b0);
        if (!cur.src && ic_kill) killed = 1;
        if (mem_d_valid) begin
          if (cur.src || !killed)
            exp_rsp_q.push_back('{src: cur.src, data: (cur.src && cur.op[2]) ? 32'h0 : mem_d_data});
          m_last = cur.src;
          busy = 0;
        end
      end

      if (busy) begin
        busy_cycles++;
        if (busy_cycles > 60) begin
          n_tests++;
          n_fail++;
          $display("FAIL txn_timeout: busy for %0d cycles, limit 60", busy_cycles);
          busy = 0;
        end
      end

      if (e_ic && ic_q.size() > 0) begin
        cur = ic_q.pop_front(); busy = 1; sent = 0; killed = 0; busy_cycles = 0;
      end else if (e_dc && dc_q.size() > 0) begin
        cur = dc_q.pop_front(); busy = 1; sent = 0; killed = 0; busy_cycles = 0;
      end
    end
  end

  // Stimulus and downstream memory responder
  bit          rand_req = 0, rand_mem = 0, kill_force = 0, stray_d = 0;
  bit          waiting_d = 0, d_use_fixed = 0;
  int          a_stall = 0, d_wait = 0, d_fixed = 0;
  logic [31:0] d_fixed_data = '0;

  task automatic raise_ic(input logic [31:0] a);
    ic_req_valid = 1; ic_req_addr = a;
    ic_q.push_back('{src: 1'b0, addr: a, data: 32'h0, op: 3'b010});
  endtask

  task automatic raise_dc(input logic [31:0] a, input logic [31:0] d, input logic [2:0] op);
    dc_req_valid = 1; dc_req_addr = a; dc_req_data = d; dc_req_op = op;
    dc_q.push_back('{src: 1'b1, addr: a, data: d, op: op});
  endtask

  function automatic logic [2:0] rand_op();
    int unsigned o = $urandom_range(0, 5);
    return (o < 3) ? 3'(o) : 3'(o + 1);
  endfunction

  task automatic tick();
    bit ic_acc, dc_acc, a_acc;
    @(negedge clk);
    ic_acc = ic_req_valid && ic_req_ready;
    dc_acc = dc_req_valid && dc_req_ready;
    a_acc  = mem_a_valid && mem_a_ready;
    @(posedge clk);
    #1;
    if (ic_acc) ic_req_valid = 0;
    if (dc_acc) dc_req_valid = 0;
    if (rand_req) begin
      if (!ic_req_valid && $urandom_range(0, 2) == 0) raise_ic($urandom);
      if (!dc_req_valid && $urandom_range(0, 2) == 0) raise_dc($urandom, $urandom, rand_op());
      ic_kill = ($urandom_range(0, 19) == 0);
    end else begin
      ic_kill = kill_force;
    end
    mem_d_valid = stray_d;
    if (a_acc) begin
      mem_a_ready = 0; waiting_d = 1;
      d_wait = rand_mem ? int'($urandom_range(0, 3)) : d_fixed;
    end else if (mem_a_valid) begin
      if (a_stall > 0) begin mem_a_ready = 0; a_stall--; end
      else mem_a_ready = rand_mem ? ($urandom_range(0, 2) == 0) : 1'b1;
    end else begin
      mem_a_ready = 0;
    end
    if (waiting_d) begin
      if (d_wait == 0) begin
        mem_d_valid = 1; waiting_d = 0;
        mem_d_data = d_use_fixed ? d_fixed_data : $urandom;
      end else begin
        d_wait--;
      end
    end
  endtask

  initial begin
    int ic_left, dc_left;
    rst = 1; ic_req_valid = 0; ic_req_addr = '0; ic_kill = 0;
    dc_req_valid = 0; dc_req_addr = '0; dc_req_data = '0; dc_req_op = '0;
    mem_a_ready = 0; mem_d_valid = 0; mem_d_data = '0;
    repeat (3) tick();
    rst = 0;

    // Contention straight after reset: icache first, then alternation
    ic_left = 4; dc_left = 4;
    for (int i = 0; i < 50; i++) begin
      if (!ic_req_valid && ic_left > 0) begin raise_ic(32'h1000 + 32'(i)); ic_left--; end
      if (!dc_req_valid && dc_left > 0) begin raise_dc(32'h2000 + 32'(i), 32'(i), 3'b010); dc_left--; end
      tick();
    end

    // Lone icache fill
    d_use_fixed = 1; d_fixed_data = 32'hDEADBEEF; d_fixed = 2;
    raise_ic(32'h100);
    repeat (10) tick();

    // Store under downstream back-pressure
    a_stall = 5; d_fixed = 1;
    raise_dc(32'h2000, 32'h55, 3'b110);
    repeat (14) tick();

    // Flush during the wait phase of a fill, then a normal data load
    d_fixed = 4; d_fixed_data = 32'hCAFEF00D;
    raise_ic(32'h400);
    tick(); tick();
    kill_force = 1; tick(); kill_force = 0;
    repeat (8) tick();
    raise_dc(32'h3000, 32'h1234, 3'b010);
    repeat (10) tick();

    // Reset while the request sits in ISSUE, then a stray response
    a_stall = 20;
    raise_dc(32'h4000, 32'h77, 3'b010);
    repeat (3) tick();
    rst = 1; dc_req_valid = 0;
    tick();
    rst = 0; a_stall = 0; waiting_d = 0; mem_a_ready = 0;
    tick();
    stray_d = 1; tick(); stray_d = 0;
    repeat (4) tick();

    // Randomised traffic
    d_use_fixed = 0; rand_req = 1; rand_mem = 1;
    repeat (3000) tick();
    rand_req = 0; kill_force = 0;
    repeat (60) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fragment_mem_arbiter.md
Name: fragment_mem_arbiter

Overview:
Shares the fragment core's single external memory port between the instruction-cache fill path and the data-cache/load-store path. It accepts one request at a time from either requester and drives it onto the downstream bus. It then routes the single response back to the requester that issued it. Round-robin fairness applies when both requesters ask in the same cycle; the block sits between icache_controller/control_unit and the shared memory fabric.

Parameters:
ADDR_WIDTH, 32, request address width
DATA_WIDTH, 32, write-data and response-data width
OP_WIDTH, 3, data-side op code width (op[2]=1 store, op[1:0] size: 0 byte, 1 half, 2 word)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
ic_req_valid  in  1  icache fill request; held until ic_req_ready
ic_req_ready  out  1  one-cycle accept pulse to icache
ic_req_addr  in  ADDR_WIDTH  icache fill address
ic_kill  in  1  icache flush; suppresses the in-flight icache response
ic_rsp_valid  out  1  icache response strobe
ic_rsp_data  out  DATA_WIDTH  icache response data
dc_req_valid  in  1  data request; held until dc_req_ready
dc_req_ready  out  1  one-cycle accept pulse to data side
dc_req_addr  in  ADDR_WIDTH  data address
dc_req_data  in  DATA_WIDTH  store data
dc_req_op  in  OP_WIDTH  data op code
dc_rsp_valid  out  1  data response strobe (load data or store ack)
dc_rsp_data  out  DATA_WIDTH  load data; 0 for stores
mem_a_valid  out  1  downstream request valid
mem_a_ready  in  1  downstream request accept
mem_a_addr  out  ADDR_WIDTH  downstream address
mem_a_data  out  DATA_WIDTH  downstream write data
mem_a_op  out  OP_WIDTH  downstream op; icache requests use op 3'b010 (word load)
mem_a_src  out  1  0 icache, 1 data side
mem_d_valid  in  1  downstream response strobe
mem_d_data  in  DATA_WIDTH  downstream response data

Behaviour:
- One clock (clk); reset rst is synchronous, active-high.
- Reset: state IDLE; all outputs 0; last_owner=1 (data side), so icache wins the first tie. Reset mid-transaction drops mem_a_valid the next edge; any later mem_d_valid is ignored.
- FSM states: IDLE, ISSUE, WAIT. At most one transaction is outstanding.
- IDLE, only one requester valid: grant that requester.
- IDLE, both requesters valid: grant the requester that is not last_owner.
- IDLE, on grant: latch addr/data/op/src into registers; pulse the owner's *_req_ready for that same cycle (combinational from valid and state); go to ISSUE.
- ISSUE: mem_a_valid=1 with the latched fields, stable until mem_a_ready. On mem_a_valid & mem_a_ready, go to WAIT. The request is never withdrawn.
- WAIT, on mem_d_valid: drive the owner's rsp_valid high for exactly one cycle, registered (the cycle after mem_d_valid). Drive rsp_data=mem_d_data, or 0 for a store. Set last_owner=src and go to IDLE.
- Latency: accept at cycle N, mem_a_valid at N+1. Response strobe arrives 1 cycle after mem_d_valid. Earliest new grant is the cycle after mem_d_valid.
- ic_kill asserted while owner=icache in ISSUE or WAIT: set a kill flag. The bus transaction still completes, but ic_rsp_valid is not raised for it.
- ic_kill in IDLE: no effect. The flag clears on entry to IDLE.
- mem_d_valid in IDLE or ISSUE: protocol error, ignored.
- Non-owner rsp_valid is always 0. rsp_data holds its last value when the strobe is low.

Optional Feature:
FRAG_MEM_ARB_PERF_EN:
- Defined: adds outputs perf_ic_grants, perf_dc_grants and perf_stall_cycles, each 32 bits.
  - The grant counters count grants.
  - perf_stall_cycles counts cycles in which a requester is valid but not granted.
  - All three reset to 0 and wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package fragment_mem_pkg holds:
  - arb_state_t enum {IDLE, ISSUE, WAIT}
  - src_t enum {SRC_IC=0, SRC_DC=1}
  - op constants OP_LB, OP_LH, OP_LW=3'b010, OP_SB, OP_SH, OP_SW
- One sub-module, rr_arbiter2: a 2-input round-robin pick from valid bits and last_owner, purely combinational.

Test Plan:
- Only ic_req_valid, addr 0x100 -> ic_req_ready pulse; next cycle mem_a_valid with addr 0x100, op 3'b010, src 0. Returning mem_d_data 0xDEADBEEF -> ic_rsp_valid one cycle later with 0xDEADBEEF; dc_rsp_valid stays 0.
- Both valid right after reset -> icache granted first, data side second, then alternation over 4 back-to-back pairs.
- Data store, addr 0x2000, data 0x55, op 3'b110; mem_a_ready held low 5 cycles -> fields stable all 5 cycles; after mem_d_valid, dc_rsp_valid=1 with dc_rsp_data=0.
- ic_kill during WAIT of an icache fill -> mem_d_valid consumed, ic_rsp_valid stays 0, the next data request is granted normally.
- rst asserted in ISSUE -> mem_a_valid=0 the next cycle; a subsequent stray mem_d_valid produces no rsp strobe.
- With FRAG_MEM_ARB_PERF_EN: 3 icache and 2 data grants -> counters read 3 and 2; stall count matches the cycles of contention.
